spi_cmd_master: RTL



---
 rtl/spi_cmd_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 command master.
// Shifts a command word, then an optional data word, MSB-first.
module spi_cmd_master #(
    parameter int CMD_W    = 32,
    parameter int DATA_W   = 32,
    parameter int HALF_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_i,
    input  logic              cmd_only_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              spi_sck_o,
    output logic              spi_scs_o,
    output logic              spi_sdo_o,
    input  logic              spi_sdi_i
);

    localparam int TW = CMD_W + DATA_W;
    localparam int BW = $clog2(TW + 1);
    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(HALF_DIV - 1);
    localparam logic [BW-1:0] CMD_N    = BW'(CMD_W);
    localparam logic [BW-1:0] CMD_LAST = BW'(CMD_W - 1);
    localparam logic [BW-1:0] ALL_LAST = BW'(TW - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOW  = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [TW-1:0]     tx_q, tx_d;
    logic [TW-1:0]     rx_q, rx_d;
    logic              rd_q, rd_d;
    logic              co_q, co_d;
    logic              sck_q, sck_d;
    logic              scs_q, scs_d;
    logic              sdo_q, sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              cnt_end;
    logic              last_bit;
    logic [BW-1:0]     next_bit;

    assign cnt_end  = (cnt_q == CNT_MAX);
    assign last_bit = (bit_q == (co_q ? CMD_LAST : ALL_LAST));
    assign next_bit = bit_q + 1'b1;

    // Next-state logic: frame sequencing, shifting and capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        co_d    = co_q;
        sck_d   = sck_q;
        scs_d   = scs_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tx_d    = {cmd_i, data_i} << 1;
                    rx_d    = '0;
                    rd_d    = rd_i;
                    co_d    = cmd_only_i;
                    sdo_d   = cmd_i[CMD_W-1];
                    scs_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = S_HIGH;
                    if (rd_q && (bit_q >= CMD_N)) begin
                        rx_d = {rx_q[TW-2:0], spi_sdi_i};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (last_bit) begin
                        state_d = S_HOLD;
                    end else begin
                        // Read frames keep SDO low for the whole data phase.
                        bit_d   = next_bit;
                        sdo_d   = tx_q[TW-1] & ~(rd_q && (next_bit >= CMD_N));
                        tx_d    = tx_q << 1;
                        state_d = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    scs_d   = 1'b1;
                    sdo_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                    if (rd_q && !co_q) begin
                        rdata_d = rx_q[DATA_W-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= 1'b0;
            co_q    <= 1'b0;
            sck_q   <= 1'b0;
            scs_q   <= 1'b1;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            co_q    <= co_d;
            sck_q   <= sck_d;
            scs_q   <= scs_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign spi_sck_o = sck_q;
    assign spi_scs_o = scs_q;
    assign spi_sdo_o = sdo_q;

endmodule
